// File: rtl/uart_mmio_pkg.sv
// Shared register map, status bit positions and FSM encodings for the UART peripheral.
// latency: n/a (declarations only); backpressure: n/a.
package uart_mmio_pkg;

   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_DIV    = 2'd2;

   localparam int ST_TX_FULL   = 0;
   localparam int ST_TX_EMPTY  = 1;
   localparam int ST_TX_BUSY   = 2;
   localparam int ST_RX_VALID  = 3;
   localparam int ST_RX_OVR    = 4;
   localparam int ST_TX_OVF    = 5;
   localparam int ST_RX_FERR   = 6;
   localparam int ST_COUNT_LSB = 8;

   localparam logic [15:0] DIV_MIN = 16'd4;

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   function automatic logic [15:0] clamp_div(input logic [15:0] d);
      return (d < DIV_MIN) ? DIV_MIN : d;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; DEPTH must be a power of two.
// latency: push visible on dout one cycle later; backpressure: push ignored when full unless a pop happens the same cycle.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = count[AW];
   assign dout    = mem[rd_ptr];
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_mmio.sv
// RAM-style bus UART: TX FIFO feeding a serialiser, RX deserialiser into a single polled holding register.
// latency: q one cycle after a selected read; backpressure: none, DATA writes to a full FIFO are dropped and flagged.
module uart_mmio
   import uart_mmio_pkg::*;
#(
   parameter int CLK_DIV    = 434,
   parameter int FIFO_DEPTH = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sel,
   input  logic [31:0] address,
   input  logic [31:0] data,
   input  logic        wren,
   output logic [31:0] q,
   output logic        uart_tx,
   input  logic        uart_rx
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [1:0]    reg_addr;
   logic          bus_wr;
   logic          bus_rd;
   logic          rd_clr;
   logic [15:0]   div;
   logic          tx_ovf;
   logic          rx_ovr;
   logic          rx_ferr;
   logic          rx_valid;
   logic [7:0]    rx_byte;
   logic [31:0]   status;
   logic [31:0]   rd_mux;
   wire           unused_bits = ^{address[31:2], data[31:16]};

   logic          fifo_push;
   logic          fifo_pop;
   logic          fifo_full;
   logic          fifo_empty;
   logic [7:0]    fifo_dout;
   logic [CW-1:0] fifo_count;

   assign reg_addr  = address[1:0];
   assign bus_wr    = sel && wren;
   assign bus_rd    = sel && !wren;
   assign rd_clr    = bus_rd && (reg_addr == REG_DATA);
   assign fifo_push = bus_wr && (reg_addr == REG_DATA);

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (data[7:0]),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // ---------------- transmit ----------------
   tx_state_t   tx_state, tx_next;
   logic [15:0] tx_cnt;
   logic [2:0]  tx_bit;
   logic [7:0]  tx_shreg;
   logic        tx_line;

   always_comb begin
      tx_next  = tx_state;
      fifo_pop = 1'b0;
      tx_line  = 1'b1;
      case (tx_state)
         TX_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               tx_next  = TX_START;
            end
         end
         TX_START: begin
            tx_line = 1'b0;
            if (tx_cnt == 16'd0) tx_next = TX_DATA;
         end
         TX_DATA: begin
            tx_line = tx_shreg[0];
            if (tx_cnt == 16'd0 && tx_bit == 3'd7) tx_next = TX_STOP;
         end
         TX_STOP: begin
            if (tx_cnt == 16'd0) begin
               if (!fifo_empty) begin
                  fifo_pop = 1'b1;
                  tx_next  = TX_START;
               end else begin
                  tx_next = TX_IDLE;
               end
            end
         end
         default: tx_next = TX_IDLE;
      endcase
   end

   // The counter reloads from div at every bit boundary, so DIV writes apply at the next bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state <= TX_IDLE;
         tx_cnt   <= '0;
         tx_bit   <= '0;
         tx_shreg <= '0;
         uart_tx  <= 1'b1;
      end else begin
         tx_state <= tx_next;
         uart_tx  <= tx_line;
         if (tx_state == TX_IDLE || tx_cnt == 16'd0) tx_cnt <= div - 16'd1;
         else                                        tx_cnt <= tx_cnt - 16'd1;
         if (tx_state == TX_START)                        tx_bit <= '0;
         else if (tx_state == TX_DATA && tx_cnt == 16'd0) tx_bit <= tx_bit + 3'd1;
         if (fifo_pop)                                    tx_shreg <= fifo_dout;
         else if (tx_state == TX_DATA && tx_cnt == 16'd0) tx_shreg <= {1'b0, tx_shreg[7:1]};
      end
   end

   // ---------------- receive ----------------
   rx_state_t   rx_state, rx_next;
   logic        rx_s1, rx_s2, rx_prev;
   logic [15:0] rx_cnt;
   logic [2:0]  rx_bit;
   logic [7:0]  rx_shreg;
   logic        rx_shift;
   logic        rx_done;
   logic        rx_store;
   logic        rx_overrun;
   logic        rx_frame_err;

   always_comb begin
      rx_next  = rx_state;
      rx_shift = 1'b0;
      rx_done  = 1'b0;
      case (rx_state)
         RX_IDLE:  if (rx_prev && !rx_s2) rx_next = RX_START;
         RX_START: if (rx_cnt == 16'd0) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
         RX_DATA: begin
            if (rx_cnt == 16'd0) begin
               rx_shift = 1'b1;
               if (rx_bit == 3'd7) rx_next = RX_STOP;
            end
         end
         RX_STOP: begin
            if (rx_cnt == 16'd0) begin
               rx_done = 1'b1;
               rx_next = RX_IDLE;
            end
         end
         default: rx_next = RX_IDLE;
      endcase
   end

   // A read-clear coinciding with a completing byte lets the new byte in.
   assign rx_store     = rx_done && rx_s2 && (!rx_valid || rd_clr);
   assign rx_overrun   = rx_done && rx_s2 && rx_valid && !rd_clr;
   assign rx_frame_err = rx_done && !rx_s2;

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_state <= RX_IDLE;
         rx_s1    <= 1'b1;
         rx_s2    <= 1'b1;
         rx_prev  <= 1'b1;
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_shreg <= '0;
      end else begin
         rx_state <= rx_next;
         rx_s1    <= uart_rx;
         rx_s2    <= rx_s1;
         rx_prev  <= rx_s2;
         if (rx_state == RX_IDLE)   rx_cnt <= (div >> 1) - 16'd1;
         else if (rx_cnt == 16'd0)  rx_cnt <= div - 16'd1;
         else                       rx_cnt <= rx_cnt - 16'd1;
         if (rx_state == RX_START)  rx_bit <= '0;
         else if (rx_shift)         rx_bit <= rx_bit + 3'd1;
         if (rx_shift)              rx_shreg <= {rx_s2, rx_shreg[7:1]};
      end
   end

   // ---------------- registers and bus ----------------
   always_comb begin
      status                           = '0;
      status[ST_TX_FULL]               = fifo_full;
      status[ST_TX_EMPTY]              = fifo_empty;
      status[ST_TX_BUSY]               = (tx_state != TX_IDLE);
      status[ST_RX_VALID]              = rx_valid;
      status[ST_RX_OVR]                = rx_ovr;
      status[ST_TX_OVF]                = tx_ovf;
      status[ST_RX_FERR]               = rx_ferr;
      status[ST_COUNT_LSB +: 8]        = 8'(fifo_count);
      case (reg_addr)
         REG_DATA:   rd_mux = {23'b0, rx_valid, rx_byte};
         REG_STATUS: rd_mux = status;
         REG_DIV:    rd_mux = {16'b0, div};
         default:    rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div      <= 16'(CLK_DIV);
         tx_ovf   <= 1'b0;
         rx_ovr   <= 1'b0;
         rx_ferr  <= 1'b0;
         rx_valid <= 1'b0;
         rx_byte  <= '0;
         q        <= '0;
      end else begin
         if (bus_wr && reg_addr == REG_DIV) div <= clamp_div(data[15:0]);

         if (fifo_push && fifo_full && !fifo_pop)                         tx_ovf <= 1'b1;
         else if (bus_wr && reg_addr == REG_STATUS && data[ST_TX_OVF])    tx_ovf <= 1'b0;
         if (rx_overrun)                                                  rx_ovr <= 1'b1;
         else if (bus_wr && reg_addr == REG_STATUS && data[ST_RX_OVR])    rx_ovr <= 1'b0;
         if (rx_frame_err)                                                rx_ferr <= 1'b1;
         else if (bus_wr && reg_addr == REG_STATUS && data[ST_RX_FERR])   rx_ferr <= 1'b0;

         if (rx_store)    rx_valid <= 1'b1;
         else if (rd_clr) rx_valid <= 1'b0;
         if (rx_store)    rx_byte  <= rx_shreg;

         if (bus_rd) q <= rd_mux;
      end
   end

endmodule

// File: tb/tb_uart_mmio.sv
// Self-checking bench for uart_mmio: register vector table, TX frame scoreboard, RX and reset sequences.
// latency: n/a; backpressure: n/a.
module tb_uart_mmio;
   import uart_mmio_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        sel;
   logic [31:0] address;
   logic [31:0] data;
   logic        wren;
   logic [31:0] q;
   logic        uart_tx;
   logic        uart_rx;

   always #5 clk = ~clk;

   uart_mmio #(.CLK_DIV(434), .FIFO_DEPTH(16)) dut (
      .clk     (clk),
      .rst     (rst),
      .sel     (sel),
      .address (address),
      .data    (data),
      .wren    (wren),
      .q       (q),
      .uart_tx (uart_tx),
      .uart_rx (uart_rx)
   );

   int         errors = 0;
   int         checks = 0;
   int         cyc_cnt = 0;
   int         wr_cyc = 0;
   int         start_cyc = 0;
   logic       mon_en = 1'b0;
   int         mon_div = 434;
   logic       burst_mode = 1'b0;
   int         burst_frames = 0;
   logic [7:0] exp_tx[$];

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      sel = 1'b1; wren = 1'b1; address = {30'b0, a}; data = d;
      @(posedge clk); #1;
      wr_cyc = cyc_cnt;
      sel = 1'b0; wren = 1'b0;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [31:0] v);
      @(negedge clk);
      sel = 1'b1; wren = 1'b0; address = {30'b0, a};
      @(posedge clk); #1;
      v = q;
      sel = 1'b0;
   endtask

   task automatic rx_send(input logic [7:0] b, input logic stop, input int div);
      @(negedge clk);
      uart_rx = 1'b0;
      repeat (div) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         repeat (div) @(negedge clk);
      end
      uart_rx = stop;
      repeat (div) @(negedge clk);
      uart_rx = 1'b1;
      repeat (6) @(negedge clk);
   endtask

   // Decodes uart_tx cycle by cycle: every level must hold exactly mon_div cycles.
   initial begin : tx_monitor
      logic       in_frame;
      int         fcyc;
      int         idle_run;
      logic       lvl;
      logic       hold_ok;
      logic [9:0] sh;
      logic [7:0] exp_b;
      in_frame = 1'b0; fcyc = 0; idle_run = 0; lvl = 1'b1; hold_ok = 1'b1; sh = '0;
      forever begin
         @(posedge clk); #2;
         if (!mon_en) begin
            in_frame = 1'b0;
            idle_run = 0;
         end else begin
            if (!in_frame) begin
               if (uart_tx === 1'b0) begin
                  if (burst_mode && burst_frames > 0) chk("tx_gap", idle_run, 0);
                  in_frame = 1'b1; fcyc = 0; hold_ok = 1'b1; sh = '0;
                  start_cyc = cyc_cnt;
               end else begin
                  idle_run++;
               end
            end
            if (in_frame) begin
               if (fcyc % mon_div == 0) begin
                  lvl = uart_tx;
                  sh[fcyc / mon_div] = uart_tx;
               end else if (uart_tx !== lvl) begin
                  hold_ok = 1'b0;
               end
               if (fcyc == 10 * mon_div - 1) begin
                  if (exp_tx.size() == 0) begin
                     checks++; errors++;
                     $display("FAIL tx_unexpected: got 0x%02h expected no frame", sh[8:1]);
                  end else begin
                     exp_b = exp_tx.pop_front();
                     chk("tx_byte", {24'b0, sh[8:1]}, {24'b0, exp_b});
                  end
                  chk("tx_stop", {31'b0, sh[9]}, 32'd1);
                  chk("tx_hold", {31'b0, hold_ok}, 32'd1);
                  if (burst_mode) burst_frames++;
                  in_frame = 1'b0;
                  idle_run = 0;
               end
               fcyc++;
            end
         end
      end
   end

   typedef struct {
      logic        wr;
      logic [1:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp_q;
   } vec_t;

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin : main
      logic [31:0] v;
      vec_t        vecs[17];
      int          n;
      int          lows;

      rst = 1'b1; sel = 1'b0; wren = 1'b0; address = '0; data = '0; uart_rx = 1'b1;
      repeat (3) @(negedge clk);
      @(posedge clk); #1;
      chk("rst_uart_tx", {31'b0, uart_tx}, 32'd1);
      chk("rst_q", q, 32'd0);
      @(negedge clk); rst = 1'b0;
      bus_read(REG_STATUS, v); chk("rst_status", v, 32'h0000_0002);
      bus_read(REG_DATA, v);   chk("rst_data", v, 32'h0000_0000);

      // Write rows expect q to keep the previous read value.
      vecs[0]  = '{1'b0, REG_DIV,    32'h0,         32'd434};
      vecs[1]  = '{1'b1, REG_DIV,    32'h0,         32'd434};
      vecs[2]  = '{1'b0, REG_DIV,    32'h0,         32'd4};
      vecs[3]  = '{1'b1, REG_DIV,    32'h3,         32'd4};
      vecs[4]  = '{1'b0, REG_DIV,    32'h0,         32'd4};
      vecs[5]  = '{1'b1, REG_DIV,    32'h5,         32'd4};
      vecs[6]  = '{1'b0, REG_DIV,    32'h0,         32'd5};
      vecs[7]  = '{1'b1, REG_DIV,    32'h0001_0008, 32'd5};
      vecs[8]  = '{1'b0, REG_DIV,    32'h0,         32'd8};
      vecs[9]  = '{1'b1, 2'd3,       32'hFFFF_FFFF, 32'd8};
      vecs[10] = '{1'b0, 2'd3,       32'h0,         32'd0};
      vecs[11] = '{1'b0, REG_DIV,    32'h0,         32'd8};
      vecs[12] = '{1'b1, REG_DIV,    32'h0000_FFFF, 32'd8};
      vecs[13] = '{1'b0, REG_DIV,    32'h0,         32'h0000_FFFF};
      vecs[14] = '{1'b1, REG_DIV,    32'h4,         32'h0000_FFFF};
      vecs[15] = '{1'b0, REG_DIV,    32'h0,         32'd4};
      vecs[16] = '{1'b0, REG_STATUS, 32'h0,         32'h0000_0002};
      for (int i = 0; i < 17; i++) begin
         if (vecs[i].wr) begin
            bus_write(vecs[i].addr, vecs[i].wdata);
            v = q;
         end else begin
            bus_read(vecs[i].addr, v);
         end
         chk($sformatf("vec%0d", i), v, vecs[i].exp_q);
      end

      // Single frame 0x55 at div 4.
      mon_div = 4; mon_en = 1'b1;
      exp_tx.push_back(8'h55);
      bus_write(REG_DATA, 32'h55);
      n = wr_cyc;
      for (int i = 0; i < 200 && exp_tx.size() != 0; i++) @(posedge clk);
      chk("tx55_done", exp_tx.size(), 32'd0);
      chk("tx55_latency", start_cyc - n, 32'd2);
      bus_read(REG_STATUS, v); chk("tx55_status", v, 32'h0000_0002);

      // 17 back-to-back frames, 18th write overflows.
      burst_frames = 0; burst_mode = 1'b1;
      for (int i = 0; i < 17; i++) begin
         exp_tx.push_back(8'(8'h10 + i));
         bus_write(REG_DATA, 32'(8'h10 + i));
      end
      bus_write(REG_DATA, 32'hEE);
      bus_read(REG_STATUS, v); chk("ovf_status", v, 32'h0000_1025);
      bus_write(REG_STATUS, 32'h20);
      bus_read(REG_STATUS, v); chk("ovf_clear", v, 32'h0000_1005);
      for (int i = 0; i < 1200 && exp_tx.size() != 0; i++) @(posedge clk);
      chk("burst_drain", exp_tx.size(), 32'd0);
      chk("burst_frames", burst_frames, 32'd17);
      burst_mode = 1'b0;
      repeat (4) @(negedge clk);
      bus_read(REG_STATUS, v); chk("burst_idle", v, 32'h0000_0002);

      // Receive path at div 8.
      bus_write(REG_DIV, 32'd8);
      rx_send(8'hA3, 1'b1, 8);
      bus_read(REG_STATUS, v); chk("rx_status", v, 32'h0000_000A);
      bus_read(REG_DATA, v);   chk("rx_data1", v, 32'h0000_01A3);
      bus_read(REG_DATA, v);   chk("rx_data2", v, 32'h0000_00A3);

      rx_send(8'h3C, 1'b1, 8);
      rx_send(8'hC5, 1'b1, 8);
      bus_read(REG_STATUS, v); chk("rx_ovr_status", v, 32'h0000_001A);
      bus_read(REG_DATA, v);   chk("rx_ovr_data", v, 32'h0000_013C);
      bus_write(REG_STATUS, 32'h10);
      bus_read(REG_STATUS, v); chk("rx_ovr_clear", v, 32'h0000_0002);

      rx_send(8'h77, 1'b0, 8);
      bus_read(REG_STATUS, v); chk("rx_ferr_status", v, 32'h0000_0042);
      bus_read(REG_DATA, v);   chk("rx_ferr_data", v, 32'h0000_003C);
      bus_write(REG_STATUS, 32'h40);

      @(negedge clk); uart_rx = 1'b0;
      repeat (2) @(negedge clk); uart_rx = 1'b1;
      repeat (40) @(negedge clk);
      bus_read(REG_STATUS, v); chk("rx_glitch", v, 32'h0000_0002);

      // Reset in the middle of a frame with three bytes still queued.
      mon_en = 1'b0;
      bus_write(REG_DIV, 32'd4);
      for (int i = 0; i < 4; i++) bus_write(REG_DATA, 32'h00);
      repeat (10) @(negedge clk);
      chk("pre_rst_low", {31'b0, uart_tx}, 32'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("mid_rst_tx", {31'b0, uart_tx}, 32'd1);
      @(negedge clk); rst = 1'b0;
      bus_read(REG_STATUS, v); chk("mid_rst_status", v, 32'h0000_0002);
      bus_read(REG_DIV, v);    chk("mid_rst_div", v, 32'd434);
      lows = 0;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk); #1;
         if (uart_tx !== 1'b1) lows++;
      end
      chk("post_rst_idle", lows, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
